// File: rtl/arm_mem_pkg.sv
// Shared data-memory definitions for the MEM stage and the external SRAM controller.
package arm_mem_pkg;

  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    RD = 2'd1,
    WR = 2'd2
  } mem_op_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing one SRAM half-access; last_o flags the final cycle.
module sram_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit pipeline loads/stores into two timed 16-bit async-SRAM accesses.
// Optional SRAM_READ_BYPASS_EN: repeat reads of the last-read word complete without an SRAM cycle.
//
// state | meaning
// IDLE  | no access; ready follows the request lines
// LO    | low half-word on the bus for WAIT_CYCLES cycles
// HI    | high half-word on the bus for WAIT_CYCLES cycles
// DONE  | ready=1 for one cycle, then back to IDLE
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DATA_MEM_BASE,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int WW = SRAM_AW - 1;

  mem_state_e    state_q, state_d;
  mem_op_e       op_q;
  logic [WW-1:0] word_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic [31:0]   a;
  logic [WW-1:0] req_word;
  logic          unused_addr_bits;
  logic          bypass_hit;
  logic          accept;
  logic          cnt_load, cnt_en, cnt_last;

  assign a                = address - BASE_ADDR;
  assign req_word         = a[SRAM_AW:2];
  assign unused_addr_bits = ^{a[31:SRAM_AW+1], a[1:0]};

  assign accept = (state_q == IDLE) && (wr_en || (rd_en && !bypass_hit));

`ifdef SRAM_READ_BYPASS_EN
  logic          valid_q;
  logic [WW-1:0] tag_q;

  assign bypass_hit = (state_q == IDLE) && rd_en && !wr_en && valid_q && (tag_q == req_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if ((state_q == IDLE) && wr_en && (req_word == tag_q)) begin
      valid_q <= 1'b0;
    end else if ((state_q == DONE) && (op_q == RD)) begin
      valid_q <= 1'b1;
      tag_q   <= word_q;
    end
  end
`else
  assign bypass_hit = 1'b0;
`endif

  sram_wait_cnt #(.W(CW)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CW'(WAIT_CYCLES - 1)),
    .en_i       (cnt_en),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d  = LO;
        cnt_load = 1'b1;
      end
      LO: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d  = HI;
          cnt_load = 1'b1;
        end
      end
      HI: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= RD;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= wr_en ? WR : RD;
        word_q  <= req_word;
        wdata_q <= write_data;
      end
      if (cnt_last && (op_q == RD)) begin
        if (state_q == LO) rdata_q[15:0]  <= sram_dq_in;
        if (state_q == HI) rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

  // we_n rises on the last cycle of each half so data is held past the strobe
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE: ready = ~(rd_en | wr_en) | bypass_hit;
      LO, HI: begin
        sram_addr = {word_q, (state_q == HI)};
        if (op_q == WR) begin
          sram_dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = cnt_last;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl against a behavioural async SRAM model.
module tb_sram_ctrl;
  import arm_mem_pkg::*;

  localparam int LAT = 2 * 5 + 1;
`ifdef SRAM_READ_BYPASS_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = LAT;
`endif

  typedef struct {
    logic [31:0] data;
    int          lat;
    bit          is_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic [15:0] mem [logic [17:0]];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  initial sram_dq_in = 16'h0000;

  always @(negedge clk) begin
    if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1) mem[sram_addr] = sram_dq_out;
    sram_dq_in = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;
  end

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 16'hxxxx;
  endfunction

  task automatic run_req(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wd, input bit release_after,
                         output int lat, output logic [31:0] rdo,
                         output bit we_lo, output bit oe_hi);
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    lat = 0; we_lo = 0; oe_hi = 0;
    #1;
    while (ready !== 1'b1 && lat < 200) begin
      if (sram_we_n === 1'b0) we_lo = 1;
      if (sram_dq_oe === 1'b1) oe_hi = 1;
      @(posedge clk); #1;
      lat++;
    end
    rdo = read_data;
    if (release_after) begin
      @(negedge clk);
      wr_en = 0; rd_en = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data} !== {1'b1, 1'b0, 18'h0, 16'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_outputs got we_n=%b oe=%b addr=%h dq=%h rd=%h want 1 0 0 0 0",
               sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
    end
    @(negedge clk); rst = 0; #1;
    n_vec++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rdo; bit wl, oh; exp_t e;
    sb.push_back('{32'h0, LAT, 1'b0});
    run_req(1, 0, 32'd1024, 32'hDEADBEEF, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat) begin n_err++; $display("FAIL store_lat got %0d want %0d", lat, e.lat); end
    n_vec++;
    if ({mem_rd(18'd1), mem_rd(18'd0)} !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL store_mem got %h%h want deadbeef", mem_rd(18'd1), mem_rd(18'd0));
    end
    n_vec++;
    if ({wl, oh} !== 2'b11) begin n_err++; $display("FAIL store_strobes got we_lo=%b oe=%b want 1 1", wl, oh); end
  endtask

  task automatic test_load;
    int lat; logic [31:0] rdo; bit wl, oh; exp_t e;
    sb.push_back('{32'hDEADBEEF, LAT, 1'b1});
    run_req(0, 1, 32'd1024, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (lat !== e.lat) begin n_err++; $display("FAIL load_lat got %0d want %0d", lat, e.lat); end
    n_vec++;
    if (rdo !== e.data) begin n_err++; $display("FAIL load_data got %h want %h", rdo, e.data); end
    n_vec++;
    if ({wl, oh} !== 2'b00) begin n_err++; $display("FAIL load_strobes got we_lo=%b oe=%b want 0 0", wl, oh); end
  endtask

  task automatic test_addr_map;
    int lat; logic [31:0] rdo; bit wl, oh; exp_t e;
    run_req(1, 0, 32'd1036, 32'h11112222, 1, lat, rdo, wl, oh);
    n_vec++;
    if ({mem_rd(18'd7), mem_rd(18'd6)} !== 32'h11112222) begin
      n_err++; $display("FAIL map_1036 got %h%h want 11112222", mem_rd(18'd7), mem_rd(18'd6));
    end
    run_req(1, 1, 32'd1039, 32'h33334444, 1, lat, rdo, wl, oh);
    n_vec++;
    if ({mem_rd(18'd7), mem_rd(18'd6)} !== 32'h33334444) begin
      n_err++; $display("FAIL map_1039_wr_wins got %h%h want 33334444", mem_rd(18'd7), mem_rd(18'd6));
    end
    sb.push_back('{32'h33334444, LAT, 1'b1});
    run_req(0, 1, 32'd1036, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (rdo !== e.data || lat !== e.lat) begin
      n_err++; $display("FAIL map_read got %h lat %0d want %h lat %0d", rdo, lat, e.data, e.lat);
    end
    run_req(1, 0, 32'd1020, 32'hCAFEF00D, 1, lat, rdo, wl, oh);
    n_vec++;
    if ({mem_rd(18'h3FFFF), mem_rd(18'h3FFFE)} !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL map_wrap got %h%h want cafef00d", mem_rd(18'h3FFFF), mem_rd(18'h3FFFE));
    end
    sb.push_back('{32'hCAFEF00D, LAT, 1'b1});
    run_req(0, 1, 32'd1020, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if ($isunknown(rdo) || rdo !== e.data) begin
      n_err++; $display("FAIL map_wrap_read got %h want %h", rdo, e.data);
    end
  endtask

  task automatic test_back_to_back;
    int lat, lat2; logic [31:0] rdo; bit wl, oh; exp_t e;
    sb.push_back('{32'hDEADBEEF, LAT, 1'b1});
    sb.push_back('{32'hDEADBEEF, HIT_LAT, 1'b1});
    run_req(0, 1, 32'd1024, 32'h0, 0, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (rdo !== e.data || lat !== e.lat) begin
      n_err++; $display("FAIL held_first got %h lat %0d want %h lat %0d", rdo, lat, e.data, e.lat);
    end
    @(posedge clk); #1;
    n_vec++;
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL held_idle got state %0d want %0d", dut.state_q, IDLE); end
    lat2 = 0;
    while (ready !== 1'b1 && lat2 < 200) begin
      @(posedge clk); #1;
      lat2++;
    end
    e = sb.pop_front();
    n_vec++;
    if (read_data !== e.data || lat2 !== e.lat) begin
      n_err++; $display("FAIL held_second got %h lat %0d want %h lat %0d", read_data, lat2, e.data, e.lat);
    end
    @(negedge clk); rd_en = 0;
  endtask

  task automatic test_mid_reset;
    int lat; logic [31:0] rdo; bit wl, oh;
    run_req(1, 0, 32'd1040, 32'h5A5A7777, 1, lat, rdo, wl, oh);
    @(negedge clk);
    wr_en = 1; address = 32'd1040; write_data = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; wr_en = 0;
    @(posedge clk); #1;
    n_vec++;
    if ({sram_we_n, sram_dq_oe, read_data} !== {1'b1, 1'b0, 32'h0} || dut.state_q !== IDLE) begin
      n_err++; $display("FAIL midrst_abort got we_n=%b oe=%b rd=%h state=%0d want 1 0 0 %0d",
                        sram_we_n, sram_dq_oe, read_data, dut.state_q, IDLE);
    end
    @(negedge clk); rst = 0;
    repeat (15) @(posedge clk);
    #1;
    n_vec++;
    if (mem_rd(18'd9) !== 16'h5A5A) begin n_err++; $display("FAIL midrst_hi got %h want 5a5a", mem_rd(18'd9)); end
  endtask

  task automatic test_bypass;
    int lat; logic [31:0] rdo; bit wl, oh; exp_t e;
    sb.push_back('{32'hDEADBEEF, LAT, 1'b1});
    sb.push_back('{32'hDEADBEEF, HIT_LAT, 1'b1});
    sb.push_back('{32'h0BADF00D, LAT, 1'b1});
    run_req(0, 1, 32'd1024, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (rdo !== e.data || lat !== e.lat) begin
      n_err++; $display("FAIL bypass_fill got %h lat %0d want %h lat %0d", rdo, lat, e.data, e.lat);
    end
    run_req(0, 1, 32'd1024, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (rdo !== e.data || lat !== e.lat) begin
      n_err++; $display("FAIL bypass_repeat got %h lat %0d want %h lat %0d", rdo, lat, e.data, e.lat);
    end
    run_req(1, 0, 32'd1024, 32'h0BADF00D, 1, lat, rdo, wl, oh);
    run_req(0, 1, 32'd1024, 32'h0, 1, lat, rdo, wl, oh);
    e = sb.pop_front();
    n_vec++;
    if (rdo !== e.data || lat !== e.lat) begin
      n_err++; $display("FAIL bypass_after_write got %h lat %0d want %h lat %0d", rdo, lat, e.data, e.lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_load();
    test_addr_map();
    test_back_to_back();
    test_mid_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
